ext_bus_regfile: RTL and testbench
==================================

// Module: ext_bus_regfile
// PURPOSE
// - Parametrised FPGA-side slave for the ARM external asynchronous memory bus (CE/OE/WE, active-low).
// - Successor to the single 16-bit shift-register slave: adds address lines, a NUM_REGS-deep register file,
//   an explicit read/write FSM, a fabric-side write port and a clean tristate enable.
// - Sits between the top-level GPIO pins (tristate buffer at top level) and fabric logic such as the 7-seg drivers.
// PARAMETERS
// - DATA_W       16   bus and register width
// - ADDR_W       3    address width; NUM_REGS = 2**ADDR_W
// - SYNC_STAGES  2    flip-flops per control-line synchroniser (>=2)
// - RESET_VAL    0    reset value of every register (DATA_W bits)
// PORTS
// - clock         in   1                  PLL system clock
// - reset         in   1                  synchronous, active-high
// - bus_ce_n      in   1                  chip enable from ARM, asynchronous
// - bus_oe_n      in   1                  output enable from ARM, asynchronous
// - bus_we_n      in   1                  write enable from ARM, asynchronous
// - bus_addr      in   ADDR_W             register address from ARM
// - bus_data_in   in   DATA_W             data pins, input view
// - bus_data_out  out  DATA_W             data to drive onto pins
// - bus_data_oe   out  1                  1 = top level drives bus_data_out onto pins
// - fab_we        in   1                  fabric write request
// - fab_addr      in   ADDR_W             fabric write address
// - fab_wdata     in   DATA_W             fabric write data
// - regs_flat     out  NUM_REGS*DATA_W    all registers, reg i at [i*DATA_W +: DATA_W]
// - wr_strobe     out  1                  1-cycle pulse on each committed bus write
// - wr_addr       out  ADDR_W             address of last committed bus write
// BEHAVIOUR
// - Reset: state IDLE, bus_data_oe=0, bus_data_out=0, wr_strobe=0, wr_addr=0, all regs=RESET_VAL, sync chains=1.
// - ce/oe/we pass through SYNC_STAGES-deep synchronisers; edges detected on synced values (prev vs current).
// - FSM states IDLE, READ, WRITE:
//   - IDLE -> WRITE: ce_n low and we_n falling edge. Takes priority if oe_n falls in the same cycle.
//   - IDLE -> READ: ce_n low and oe_n falling edge, no we_n falling edge.
//   - READ: bus_data_oe=1; bus_data_out = reg[bus_addr], re-registered every cycle, 1-cycle latency.
//   - READ -> IDLE: oe_n high or ce_n high (synced); bus_data_oe drops on that same clock edge.
//   - WRITE: bus_data_oe=0; bus_addr/bus_data_in copied into shadow regs every cycle while synced we_n is low.
//   - WRITE -> IDLE (commit): we_n rising edge with ce_n low; reg[shadow_addr] <= shadow_data;
//     wr_strobe=1 for one cycle; wr_addr updated.
//   - WRITE -> IDLE (abort): ce_n rises before we_n; no commit, no strobe.
// - bus_data_oe is never 1 outside READ, so the bus is never driven during a write.
// - Fabric write: reg[fab_addr] <= fab_wdata in any state. On the same cycle as a bus commit to the same address,
//   the bus wins. Different addresses both write.
// - A fabric write during READ is visible on bus_data_out on the next cycle.
// - Reset asserted mid-transaction: abort immediately to reset values. The bus is released within the reset cycle.
// CONFIGURATION
// - BUS_IRQ_EN defined: adds ports irq_set (in, 1) and irq (out, 1, reset 0).
//   - irq_set=1 sets irq. A committed bus write to address NUM_REGS-1 clears irq.
//   - Set and clear in the same cycle: set wins.
// - BUS_IRQ_EN undefined: no irq ports or logic; address NUM_REGS-1 is an ordinary register.
// STRUCTURE
// - ext_bus_pkg: FSM state enum (IDLE/READ/WRITE), localparam NUM_REGS function, default widths.
// - Sub-module bus_sync_edge: SYNC_STAGES synchroniser with rise/fall outputs. One instance per control line.
// - The register file is a flat array in this module. No RAM inference is required.
// TESTING
// - Reset, then bus write 0x1234 to addr 3 -> reg3=0x1234, one wr_strobe, wr_addr=3, bus_data_oe=0 throughout.
// - Read addr 3 after that write -> bus_data_oe=1 within SYNC_STAGES+2 cycles of oe_n fall, data 0x1234,
//   oe low again within SYNC_STAGES+1 cycles of oe_n rise.
// - ce_n rises during WRITE before we_n -> reg unchanged, no wr_strobe.
// - oe_n and we_n fall together -> WRITE taken, bus_data_oe stays 0.
// - Fabric write 0xAAAA and bus commit 0x5555 to addr 1 in the same cycle -> reg1=0x5555.
//   Different addresses -> both regs written.
// - BUS_IRQ_EN: irq_set pulse -> irq=1; bus write to addr 7 (ADDR_W=3) -> irq=0; reset during READ -> oe=0 next edge.

Source files
------------

// File: rtl/ext_bus_regfile_pkg.sv
// Shared types and sizing helpers for the external asynchronous bus register file.
// Optional feature macro used by the design: BUS_IRQ_EN.
package ext_bus_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 3;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } bus_state_e;

    function automatic int num_regs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ext_bus_regfile_sync_edge.sv
// Multi-flop synchroniser for one asynchronous active-low control line, with
// rise/fall pulses derived from the synchronised value. Chain resets to 1 (line idle).
module bus_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic [SYNC_STAGES-1:0] chain_d;
    logic                   prev_q;

    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], async_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= chain_d;
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/ext_bus_regfile.sv
// FPGA-side slave for the ARM asynchronous memory bus: register file with read/write FSM,
// fabric write port and tristate enable. Define BUS_IRQ_EN to add the irq_set/irq ports.
module ext_bus_regfile
    import ext_bus_pkg::*;
#(
    parameter int                  DATA_W      = DEF_DATA_W,
    parameter int                  ADDR_W      = DEF_ADDR_W,
    parameter int                  SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               bus_ce_n,
    input  logic                               bus_oe_n,
    input  logic                               bus_we_n,
    input  logic [ADDR_W-1:0]                  bus_addr,
    input  logic [DATA_W-1:0]                  bus_data_in,
    output logic [DATA_W-1:0]                  bus_data_out,
    output logic                               bus_data_oe,
    input  logic                               fab_we,
    input  logic [ADDR_W-1:0]                  fab_addr,
    input  logic [DATA_W-1:0]                  fab_wdata,
    output logic [(2**ADDR_W)*DATA_W-1:0]      regs_flat,
    output logic                               wr_strobe,
    output logic [ADDR_W-1:0]                  wr_addr,
`ifdef BUS_IRQ_EN
    input  logic                               irq_set,
    output logic                               irq,
`endif
    output bus_state_e                         dbg_state
);

    localparam int NUM_REGS = num_regs(ADDR_W);

    logic ce_sync, ce_rise, ce_fall;
    logic oe_sync, oe_rise, oe_fall;
    logic we_sync, we_rise, we_fall;
    logic unused_edges;

    bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ce (
        .clk_i(clock), .rst_i(reset), .async_i(bus_ce_n),
        .sync_o(ce_sync), .rise_o(ce_rise), .fall_o(ce_fall)
    );
    bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_oe (
        .clk_i(clock), .rst_i(reset), .async_i(bus_oe_n),
        .sync_o(oe_sync), .rise_o(oe_rise), .fall_o(oe_fall)
    );
    bus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_we (
        .clk_i(clock), .rst_i(reset), .async_i(bus_we_n),
        .sync_o(we_sync), .rise_o(we_rise), .fall_o(we_fall)
    );

    // Only levels of ce and oe matter for leaving a transaction.
    assign unused_edges = ^{ce_rise, ce_fall, oe_rise};

    bus_state_e          state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [ADDR_W-1:0]   shadow_addr_q, shadow_addr_d;
    logic [DATA_W-1:0]   shadow_data_q, shadow_data_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                oe_q, oe_d;
    logic                strobe_q, strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                commit;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write start wins over a read start seen in the same cycle.
                if (!ce_sync && we_fall) begin
                    state_d = ST_WRITE;
                end else if (!ce_sync && oe_fall) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (oe_sync || ce_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (we_rise && !ce_sync) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (ce_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shadow_addr_d = shadow_addr_q;
        shadow_data_d = shadow_data_q;
        if (state_d == ST_WRITE && !we_sync) begin
            shadow_addr_d = bus_addr;
            shadow_data_d = bus_data_in;
        end

        // Bus commit is applied last so it overrides a fabric write to the same address.
        regs_d = regs_q;
        if (fab_we) begin
            regs_d[fab_addr] = fab_wdata;
        end
        if (commit) begin
            regs_d[shadow_addr_q] = shadow_data_q;
        end

        oe_d       = (state_d == ST_READ);
        data_out_d = (state_d == ST_READ) ? regs_q[bus_addr] : '0;
        strobe_d   = commit;
        wr_addr_d  = commit ? shadow_addr_q : wr_addr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shadow_addr_q <= '0;
            shadow_data_q <= '0;
            data_out_q    <= '0;
            oe_q          <= 1'b0;
            strobe_q      <= 1'b0;
            wr_addr_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q       <= state_d;
            shadow_addr_q <= shadow_addr_d;
            shadow_data_q <= shadow_data_d;
            data_out_q    <= data_out_d;
            oe_q          <= oe_d;
            strobe_q      <= strobe_d;
            wr_addr_q     <= wr_addr_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef BUS_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (commit && shadow_addr_q == ADDR_W'(NUM_REGS - 1)) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // Gating with reset releases the pins inside the reset cycle, not one edge later.
    assign bus_data_oe  = oe_q & ~reset;
    assign bus_data_out = data_out_q;
    assign wr_strobe    = strobe_q;
    assign wr_addr      = wr_addr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ext_bus_regfile.sv
// Directed bench for ext_bus_regfile with default parameters (16-bit data, 8 regs, 2-stage sync).
// Build with +define+BUS_IRQ_EN to also exercise the irq feature.
module tb_ext_bus_regfile;
    import ext_bus_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     bus_ce_n, bus_oe_n, bus_we_n;
    logic [ADDR_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_data_in;
    logic [DATA_W-1:0]        bus_data_out;
    logic                     bus_data_oe;
    logic                     fab_we;
    logic [ADDR_W-1:0]        fab_addr;
    logic [DATA_W-1:0]        fab_wdata;
    logic [NREGS*DATA_W-1:0]  regs_flat;
    logic                     wr_strobe;
    logic [ADDR_W-1:0]        wr_addr;
    bus_state_e               dbg_state;
`ifdef BUS_IRQ_EN
    logic                     irq_set;
    logic                     irq;
`endif

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;

    ext_bus_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2), .RESET_VAL('0)) dut (
        .clock(clock), .reset(reset),
        .bus_ce_n(bus_ce_n), .bus_oe_n(bus_oe_n), .bus_we_n(bus_we_n),
        .bus_addr(bus_addr), .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .fab_we(fab_we), .fab_addr(fab_addr), .fab_wdata(fab_wdata),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
`ifdef BUS_IRQ_EN
        .irq_set(irq_set), .irq(irq),
`endif
        .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Passive monitors sampled on the inactive edge
    always @(negedge clock) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
        if (bus_data_oe === 1'b1) oe_cnt++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] reg_of(input int a);
        return regs_flat[a*DATA_W +: DATA_W];
    endfunction

    // Driver: full bus write; optional fabric write placed on the commit cycle.
    task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic fen, input logic [ADDR_W-1:0] fa,
                             input logic [DATA_W-1:0] fd);
        bus_addr = a; bus_data_in = d; bus_ce_n = 1'b0;
        tick(3);
        bus_we_n = 1'b0;
        tick(4);
        bus_we_n = 1'b1;
        tick(2);
        fab_we = fen; fab_addr = fa; fab_wdata = fd;
        tick(1);
        chk("strobe_on_commit_edge", {127'd0, wr_strobe}, 128'd1);
        fab_we = 1'b0;
        tick(1);
        bus_ce_n = 1'b1;
        tick(3);
    endtask

    initial begin
        int s0, o0, k;
        logic [127:0] exp_flat;

        reset = 1'b1;
        bus_ce_n = 1'b1; bus_oe_n = 1'b1; bus_we_n = 1'b1;
        bus_addr = '0; bus_data_in = '0;
        fab_we = 1'b0; fab_addr = '0; fab_wdata = '0;
`ifdef BUS_IRQ_EN
        irq_set = 1'b0;
`endif
        tick(3);
        reset = 1'b0;
        tick(1);

        chk("rst_state", {126'd0, dbg_state}, {126'd0, ST_IDLE});
        chk("rst_oe", {127'd0, bus_data_oe}, 128'd0);
        chk("rst_dout", {112'd0, bus_data_out}, 128'd0);
        chk("rst_strobe", {127'd0, wr_strobe}, 128'd0);
        chk("rst_wr_addr", {125'd0, wr_addr}, 128'd0);
        chk("rst_regs", regs_flat, 128'd0);
`ifdef BUS_IRQ_EN
        chk("rst_irq", {127'd0, irq}, 128'd0);
`endif

        // Plain bus write 0x1234 -> reg3
        s0 = strobe_cnt; o0 = oe_cnt;
        bus_write(3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        chk("wr_reg3", {112'd0, reg_of(3)}, 128'h1234);
        chk("wr_one_strobe", 128'(strobe_cnt - s0), 128'd1);
        chk("wr_addr3", {125'd0, wr_addr}, 128'd3);
        chk("wr_no_oe", 128'(oe_cnt - o0), 128'd0);

        // Read reg3: oe within SYNC_STAGES+2 cycles of oe_n fall
        bus_addr = 3'd3; bus_ce_n = 1'b0;
        tick(3);
        bus_oe_n = 1'b0;
        k = 0;
        while (k < 4 && bus_data_oe !== 1'b1) begin
            tick(1);
            k++;
        end
        chk("rd_oe_rise", {127'd0, bus_data_oe}, 128'd1);
        chk("rd_data", {112'd0, bus_data_out}, 128'h1234);

        // Fabric write during read shows up one cycle later
        fab_we = 1'b1; fab_addr = 3'd3; fab_wdata = 16'hBEEF;
        tick(1);
        fab_we = 1'b0;
        tick(1);
        chk("rd_fab_visible", {112'd0, bus_data_out}, 128'hBEEF);

        bus_oe_n = 1'b1;
        k = 0;
        while (k < 3 && bus_data_oe !== 1'b0) begin
            tick(1);
            k++;
        end
        chk("rd_oe_fall", {127'd0, bus_data_oe}, 128'd0);
        bus_ce_n = 1'b1;
        tick(3);

        // Abort: ce_n rises before we_n
        s0 = strobe_cnt;
        bus_addr = 3'd2; bus_data_in = 16'h7777; bus_ce_n = 1'b0;
        tick(3);
        bus_we_n = 1'b0;
        tick(4);
        bus_ce_n = 1'b1;
        tick(4);
        bus_we_n = 1'b1;
        tick(4);
        chk("abort_reg2", {112'd0, reg_of(2)}, 128'h0);
        chk("abort_no_strobe", 128'(strobe_cnt - s0), 128'd0);
        chk("abort_idle", {126'd0, dbg_state}, {126'd0, ST_IDLE});

        // oe_n and we_n fall together: write wins, bus not driven
        o0 = oe_cnt;
        bus_addr = 3'd6; bus_data_in = 16'h6666; bus_ce_n = 1'b0;
        tick(3);
        bus_oe_n = 1'b0; bus_we_n = 1'b0;
        tick(4);
        chk("both_state_write", {126'd0, dbg_state}, {126'd0, ST_WRITE});
        bus_we_n = 1'b1;
        tick(4);
        bus_oe_n = 1'b1; bus_ce_n = 1'b1;
        tick(3);
        chk("both_reg6", {112'd0, reg_of(6)}, 128'h6666);
        chk("both_no_oe", 128'(oe_cnt - o0), 128'd0);

        // Same-address collision: bus wins
        bus_write(3'd1, 16'h5555, 1'b1, 3'd1, 16'hAAAA);
        chk("coll_reg1", {112'd0, reg_of(1)}, 128'h5555);
        // Different addresses: both land
        bus_write(3'd4, 16'h5555, 1'b1, 3'd5, 16'hAAAA);
        chk("diff_reg4", {112'd0, reg_of(4)}, 128'h5555);
        chk("diff_reg5", {112'd0, reg_of(5)}, 128'hAAAA);
        chk("diff_wr_addr", {125'd0, wr_addr}, 128'd4);

        exp_flat = '0;
        exp_flat[1*16 +: 16] = 16'h5555;
        exp_flat[3*16 +: 16] = 16'hBEEF;
        exp_flat[4*16 +: 16] = 16'h5555;
        exp_flat[5*16 +: 16] = 16'hAAAA;
        exp_flat[6*16 +: 16] = 16'h6666;
        chk("regs_flat_all", regs_flat, exp_flat);

`ifdef BUS_IRQ_EN
        irq_set = 1'b1;
        tick(1);
        irq_set = 1'b0;
        chk("irq_set", {127'd0, irq}, 128'd1);
        bus_write(3'd7, 16'h0007, 1'b0, 3'd0, 16'h0);
        chk("irq_clear", {127'd0, irq}, 128'd0);
        chk("irq_reg7", {112'd0, reg_of(7)}, 128'h0007);
`endif

        // Reset in the middle of a read
        bus_addr = 3'd4; bus_ce_n = 1'b0;
        tick(3);
        bus_oe_n = 1'b0;
        tick(4);
        chk("mid_rd_oe", {127'd0, bus_data_oe}, 128'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_oe_now", {127'd0, bus_data_oe}, 128'd0);
        tick(1);
        chk("rst_mid_state", {126'd0, dbg_state}, {126'd0, ST_IDLE});
        chk("rst_mid_regs", regs_flat, 128'd0);
        chk("rst_mid_wr_addr", {125'd0, wr_addr}, 128'd0);
        bus_oe_n = 1'b1; bus_ce_n = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("post_rst_oe", {127'd0, bus_data_oe}, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
